// File: rtl/reg_buf_fifo.sv
// Single-clock register FIFO used as the stream-side skid buffer.
//  clk_i        clock
//  rst_i        synchronous reset, active-high; clears entries, pointers, occupancy
//  clr_i        synchronous clear of pointers and occupancy (entries kept)
//  push_i       write push_data_i at tail
//  push_data_i  word to store
//  pop_i        advance head (caller guarantees non-empty)
//  head_data_o  word at head
//  occ_o        number of stored words, 0..DEPTH
module reg_buf_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int AW         = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [AW:0]           occ_o
);
  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [AW-1:0]                    head, tail;
  logic [AW:0]                      occ;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem  <= '0;
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (clr_i) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push_i) begin
        mem[tail] <= push_data_i;
        tail      <= tail + 1'b1;
      end
      if (pop_i) head <= head + 1'b1;
      case ({push_i, pop_i})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data_o = mem[head];
  assign occ_o       = occ;
endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for a dual-clock FIFO with 1-cycle read latency.
// Drains the FIFO into a small buffer and presents it as a valid/ready stream.
// Reads are issued only when the buffer has room for every word already in
// flight, so back-pressure never overruns the buffer.
//  clk_i           clock (FIFO read clock)
//  rst_i           synchronous reset, active-high
//  fifo_empty_i    FIFO empty flag
//  fifo_rd_en_o    FIFO read enable
//  fifo_rd_data_i  FIFO read data, valid one cycle after fifo_rd_en_o
//  flush_i         drop all buffered and in-flight words
//  m_valid_o       stream valid
//  m_ready_i       stream ready
//  m_data_o        stream data (buffer head)
//  words_o         count of completed stream handshakes (wrapping)
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_AW     = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  input  logic                  flush_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [CNT_WIDTH-1:0]  words_o
);
  localparam int BUF_DEPTH = 1 << BUF_AW;

  logic [BUF_AW:0]      occ;
  logic [BUF_AW+1:0]    committed;
  logic                 pend, discard;
  logic                 push, pop, credit;
  logic [CNT_WIDTH-1:0] words_q;

  // Buffered words plus the one possibly in flight must fit; no m_ready_i path.
  assign committed    = {1'b0, occ} + {{(BUF_AW+1){1'b0}}, pend};
  assign credit       = committed < (BUF_AW+2)'(BUF_DEPTH);
  assign fifo_rd_en_o = !rst_i && !flush_i && !fifo_empty_i && credit;

  assign m_valid_o = (occ != '0) && !flush_i;
  assign pop       = m_valid_o && m_ready_i;
  // Flush wins over a word landing this cycle.
  assign push      = pend && !discard && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend    <= 1'b0;
      discard <= 1'b0;
      words_q <= '0;
    end else begin
      pend    <= fifo_rd_en_o;
      // A read still in flight at flush time must not land afterwards.
      discard <= flush_i ? pend : 1'b0;
      if (pop) words_q <= words_q + 1'b1;
    end
  end

  reg_buf_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (BUF_AW)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (flush_i),
    .push_i      (push),
    .push_data_i (fifo_rd_data_i),
    .pop_i       (pop),
    .head_data_o (m_data_o),
    .occ_o       (occ)
  );

  assign words_o = words_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data = '0;
  logic        flush = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic [31:0] words;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(16), .BUF_AW(2), .CNT_WIDTH(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_en_o   (fifo_rd_en),
    .fifo_rd_data_i (fifo_rd_data),
    .flush_i        (flush),
    .m_valid_o      (m_valid),
    .m_ready_i      (m_ready),
    .m_data_o       (m_data),
    .words_o        (words)
  );

  // Source FIFO model: 1-cycle read latency, flags reads while empty.
  logic [15:0] fmem [0:255];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic empty_force = 1'b0;
  logic fifo_clr = 1'b0;
  int   underflow = 0;
  int   reads = 0;

  assign fifo_empty = (wr_ptr == rd_ptr) || empty_force;

  always @(posedge clk) begin
    if (fifo_clr) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      if (fifo_empty) underflow <= underflow + 1;
      else begin
        fifo_rd_data <= fmem[rd_ptr[7:0]];
        rd_ptr       <= rd_ptr + 1;
      end
      reads <= reads + 1;
    end
  end

  // Handshake monitor, sampled mid-cycle.
  logic [15:0] out_q [$];
  always @(negedge clk)
    if (!rst && m_valid && m_ready) out_q.push_back(m_data);

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [15:0] d);
    fmem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", m_data); end
    checks++; if (words !== 32'd0) begin failures++; $display("FAIL reset_words got=%0d exp=0", words); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    out_q.delete();
    push_word(16'hA5A5);
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL single_rd_en_n got=%b exp=1", fifo_rd_en); end
    tick();
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL single_rd_en_n1 got=%b exp=0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_valid_n1 got=%b exp=0", m_valid); end
    tick();
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL single_valid_n2 got=%b exp=1", m_valid); end
    checks++; if (m_data !== 16'hA5A5) begin failures++; $display("FAIL single_data got=%h exp=a5a5", m_data); end
    tick();
    checks++; if (words !== 32'd1) begin failures++; $display("FAIL single_words got=%0d exp=1", words); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_valid_after got=%b exp=0", m_valid); end
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(16'(i));
    tick(); tick();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'(i)) begin
        failures++; $display("FAIL stream_word%0d got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, 16'(i));
      end
      tick();
    end
    checks++; if (words !== 32'd17) begin failures++; $display("FAIL stream_words got=%0d exp=17", words); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_end got=%b exp=0", m_valid); end
  endtask

  task automatic test_back_pressure();
    int r0;
    m_ready = 1'b0;
    out_q.delete();
    r0 = reads;
    for (int i = 0; i < 10; i++) push_word(16'h0100 + 16'(i));
    repeat (6) tick();
    checks++; if (reads - r0 != 4) begin failures++; $display("FAIL bp_reads got=%0d exp=4", reads - r0); end
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL bp_rd_en got=%b exp=0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h0100) begin failures++; $display("FAIL bp_hold1 got v=%b d=%h exp v=1 d=0100", m_valid, m_data); end
    repeat (3) tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h0100) begin failures++; $display("FAIL bp_hold2 got v=%b d=%h exp v=1 d=0100", m_valid, m_data); end
    m_ready = 1'b1;
    repeat (20) tick();
    checks++; if (out_q.size() != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", out_q.size()); end
    for (int i = 0; i < 10 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== 16'h0100 + 16'(i)) begin failures++; $display("FAIL bp_order%0d got=%h exp=%h", i, out_q[i], 16'h0100 + 16'(i)); end
    end
    checks++; if (words !== 32'd27) begin failures++; $display("FAIL bp_words got=%0d exp=27", words); end
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    out_q.delete();
    for (int i = 0; i < 5; i++) push_word(16'h0200 + 16'(i));
    repeat (4) tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h0200) begin failures++; $display("FAIL flush_pre got v=%b d=%h exp v=1 d=0200", m_valid, m_data); end
    flush = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin failures++; $display("FAIL flush_gate got rd=%b v=%b exp rd=0 v=0", fifo_rd_en, m_valid); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_valid_after got=%b exp=0", m_valid); end
    checks++; if (words !== 32'd27) begin failures++; $display("FAIL flush_words got=%0d exp=27", words); end
    checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL flush_reread got=%b exp=1", fifo_rd_en); end
    tick(); tick();
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h0204) begin failures++; $display("FAIL flush_next_word got v=%b d=%h exp v=1 d=0204", m_valid, m_data); end
    m_ready = 1'b1;
    tick();
    checks++; if (words !== 32'd28) begin failures++; $display("FAIL flush_words_end got=%0d exp=28", words); end
    checks++; if (out_q.size() != 1) begin failures++; $display("FAIL flush_out_count got=%0d exp=1", out_q.size()); end
  endtask

  task automatic test_empty_toggle();
    int u0;
    logic [31:0] w0;
    out_q.delete();
    u0 = underflow;
    w0 = words;
    for (int i = 0; i < 12; i++) push_word(16'h0300 + 16'(i));
    for (int c = 0; c < 80; c++) begin
      empty_force = ((c / 2) % 2) == 0;
      m_ready     = 1'($urandom_range(0, 1));
      tick();
    end
    empty_force = 1'b0;
    m_ready     = 1'b1;
    repeat (20) tick();
    checks++; if (underflow != u0) begin failures++; $display("FAIL toggle_underflow got=%0d exp=%0d", underflow, u0); end
    checks++; if (out_q.size() != 12) begin failures++; $display("FAIL toggle_count got=%0d exp=12", out_q.size()); end
    for (int i = 0; i < 12 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== 16'h0300 + 16'(i)) begin failures++; $display("FAIL toggle_order%0d got=%h exp=%h", i, out_q[i], 16'h0300 + 16'(i)); end
    end
    checks++; if (words - w0 !== 32'd12) begin failures++; $display("FAIL toggle_words got=%0d exp=12", words - w0); end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    out_q.delete();
    for (int i = 0; i < 5; i++) push_word(16'h0400 + 16'(i));
    repeat (3) tick();
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b exp=1", m_valid); end
    rst = 1'b1;
    fifo_clr = 1'b1;
    tick();
    checks++; if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got rd=%b v=%b exp 0 0", fifo_rd_en, m_valid); end
    checks++; if (m_data !== 16'h0 || words !== 32'd0) begin failures++; $display("FAIL rstmid_vals got d=%h w=%0d exp d=0000 w=0", m_data, words); end
    tick();
    rst = 1'b0;
    fifo_clr = 1'b0;
    for (int i = 0; i < 3; i++) push_word(16'h0500 + 16'(i));
    m_ready = 1'b1;
    repeat (8) tick();
    checks++; if (out_q.size() != 3) begin failures++; $display("FAIL rstmid_count got=%0d exp=3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== 16'h0500 + 16'(i)) begin failures++; $display("FAIL rstmid_order%0d got=%h exp=%h", i, out_q[i], 16'h0500 + 16'(i)); end
    end
    checks++; if (words !== 32'd3) begin failures++; $display("FAIL rstmid_words got=%0d exp=3", words); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_back_pressure();
    test_flush();
    test_empty_toggle();
    test_reset_mid();
    checks++; if (underflow != 0) begin failures++; $display("FAIL underflow_total got=%0d exp=0", underflow); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
